// File: rtl/imem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_ctrl_pkg
// Description : Shared types and constants for the instruction-memory
//               load/run sequencer: sequencer state encoding, core
//               read/write mode values and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_ctrl_pkg;

    // Default geometry of the instruction memory and core interface
    localparam int ADDR_W_DEFAULT     = 8;
    localparam int DATA_W_DEFAULT     = 32;
    localparam int RST_CYCLES_DEFAULT = 2;

    // Width of the shared hold/run timer
    localparam int TIMER_W = 16;

    // Core RW control values
    localparam logic CORE_RW_LOAD = 1'b0;
    localparam logic CORE_RW_EXEC = 1'b1;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_CORE_RST = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/run_timer.sv
`default_nettype none
// ============================================================================
// Module      : run_timer
// Description : Enable/clear up-counter with saturation at all-ones and a
//               terminal-count compare against a caller-supplied limit.
//               Shared by the sequencer for the core reset hold and for the
//               execute-cycle budget.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_clr         - synchronous clear (wins over i_en)
//               i_en          - count enable
//               i_limit       - terminal-count compare value
//               o_count       - current count
//               o_hit         - o_count == i_limit
// Revision    : 1.0 - initial release
// ============================================================================
module run_timer
    import imem_ctrl_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_hit
);

    localparam logic [WIDTH-1:0] c_count_max = '1;
    localparam logic [WIDTH-1:0] c_count_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Saturates rather than wrapping so an unbounded run never looks like a
    // fresh run to anyone watching the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_count_max)) begin
            r_count <= r_count + c_count_one;
        end
    end

    assign o_count = r_count;
    assign o_hit   = (r_count == i_limit);

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl
// Description : Program-load and run sequencer for the single-cycle core.
//               Streams instruction words into consecutive instruction-memory
//               addresses while the core is held in reset in write mode,
//               then releases the core in execute mode for a programmable
//               number of cycles and freezes it when the budget is spent.
// Ports       : clk, rst                    - clock, sync active-high reset
//               load_start, run_len, abort  - sequencer control
//               in_valid/in_data/in_last    - instruction stream (in_ready)
//               imem_we/imem_addr/imem_wdata- instruction-memory write port
//               core_rst/core_en/core_rw    - core control
//               word_count, cycle_count     - progress counters
//               busy, done, err             - status
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int RST_CYCLES = RST_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic [TIMER_W-1:0]  run_len,
    input  logic                abort,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [DATA_W-1:0]   imem_wdata,
    output logic                core_rst,
    output logic                core_en,
    output logic                core_rw,
    output logic [ADDR_W:0]     word_count,
    output logic [TIMER_W-1:0]  cycle_count,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_W-1:0]  c_ptr_one   = ADDR_W'(1);
    localparam logic [ADDR_W:0]    c_wc_one    = (ADDR_W + 1)'(1);
    localparam logic [TIMER_W-1:0] c_tmr_one   = TIMER_W'(1);
    // The hold counter starts at 0 on entry, so the last hold cycle is N-1
    localparam logic [TIMER_W-1:0] c_hold_last = TIMER_W'(RST_CYCLES - 1);

    state_e              r_state;
    state_e              w_next;

    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W:0]     r_word_count;
    logic [TIMER_W-1:0]  r_run_len;
    logic                r_err;

    logic                w_in_load;
    logic                w_accept;
    logic                w_ptr_last;
    logic                w_start;
    logic                w_overflow;

    logic                w_tmr_clr;
    logic                w_tmr_en;
    logic [TIMER_W-1:0]  w_tmr_limit;
    logic [TIMER_W-1:0]  w_tmr_count;
    logic                w_tmr_hit;

    // ------------------------------------------------------------------
    // Handshake and datapath qualifiers
    // ------------------------------------------------------------------
    // in_ready depends on registered state only, so no in_valid -> in_ready
    // path exists.
    assign w_in_load  = (r_state == ST_LOAD);
    assign w_accept   = w_in_load & in_valid;
    assign w_ptr_last = &r_wptr;
    // A load may only begin from a quiescent state, and abort outranks it
    assign w_start    = load_start & ~abort &
                        ((r_state == ST_IDLE) | (r_state == ST_DONE));
    // Memory full without seeing the final word: the program cannot fit
    assign w_overflow = w_accept & w_ptr_last & ~in_last & ~abort;

    // ------------------------------------------------------------------
    // Shared timer: core-reset hold in CORE_RST, execute budget in RUN
    // ------------------------------------------------------------------
    run_timer #(
        .WIDTH   (TIMER_W)
    ) u_run_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_limit (w_tmr_limit),
        .o_count (w_tmr_count),
        .o_hit   (w_tmr_hit)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        w_tmr_limit = r_run_len - c_tmr_one;
        in_ready    = 1'b0;
        core_rst    = 1'b1;
        core_en     = 1'b0;
        core_rw     = CORE_RW_LOAD;
        busy        = 1'b0;
        done        = 1'b0;
        cycle_count = '0;

        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) begin
                    if (in_last) begin
                        w_next    = ST_CORE_RST;
                        w_tmr_clr = 1'b1;
                    end else if (w_ptr_last) begin
                        w_next = ST_DONE;
                    end
                end
            end

            ST_CORE_RST: begin
                core_rw     = CORE_RW_EXEC;
                busy        = 1'b1;
                w_tmr_en    = 1'b1;
                w_tmr_limit = c_hold_last;
                if (w_tmr_hit) begin
                    // Clearing here makes cycle_count read 0 on the first
                    // enabled cycle.
                    w_next    = ST_RUN;
                    w_tmr_clr = 1'b1;
                end
            end

            ST_RUN: begin
                core_rst    = 1'b0;
                core_en     = 1'b1;
                core_rw     = CORE_RW_EXEC;
                busy        = 1'b1;
                w_tmr_en    = 1'b1;
                cycle_count = w_tmr_count;
                // A zero budget never terminates; the timer just saturates.
                if ((r_run_len != '0) && w_tmr_hit) begin
                    w_next = ST_DONE;
                end
            end

            ST_DONE: begin
                core_rst    = 1'b0;
                core_rw     = CORE_RW_EXEC;
                done        = 1'b1;
                // Holds the final count (equal to the budget) for inspection
                cycle_count = w_tmr_count;
                if (load_start) begin
                    w_next = ST_LOAD;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Abort outranks every transition above
        if (abort) begin
            w_next    = ST_IDLE;
            w_tmr_clr = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Instruction-memory write port: zero-latency pass-through of the beat
    // ------------------------------------------------------------------
    always_comb begin
        imem_we    = w_accept;
        imem_addr  = w_in_load ? r_wptr  : '0;
        imem_wdata = w_in_load ? in_data : '0;
    end

    // ------------------------------------------------------------------
    // Load bookkeeping: write pointer, word count, budget, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_word_count <= '0;
            r_run_len    <= '0;
            r_err        <= 1'b0;
        end else if (w_start) begin
            r_wptr       <= '0;
            r_word_count <= '0;
            r_run_len    <= run_len;
            r_err        <= 1'b0;
        end else if (w_accept) begin
            // The word is already in memory, so it is counted even if an
            // abort arrives in the same cycle.
            r_wptr       <= r_wptr + c_ptr_one;
            r_word_count <= r_word_count + c_wc_one;
            if (w_overflow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign word_count = r_word_count;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_load_ctrl
// Description : Self-checking bench for imem_load_ctrl. Programs are built
//               as word queues; expected writes, counts and timing follow
//               from the program length, hold length and run budget.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int RC  = 2;
    localparam int SAW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic           rst;
    logic           load_start;
    logic [15:0]    run_len;
    logic           abort;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_last;
    logic           in_ready;
    logic           imem_we;
    logic [AW-1:0]  imem_addr;
    logic [DW-1:0]  imem_wdata;
    logic           core_rst;
    logic           core_en;
    logic           core_rw;
    logic [AW:0]    word_count;
    logic [15:0]    cycle_count;
    logic           busy;
    logic           done;
    logic           err;

    // Small-memory instance signals
    logic           s_load_start;
    logic [15:0]    s_run_len;
    logic           s_abort;
    logic           s_in_valid;
    logic [DW-1:0]  s_in_data;
    logic           s_in_last;
    logic           s_in_ready;
    logic           s_imem_we;
    logic [SAW-1:0] s_imem_addr;
    logic [DW-1:0]  s_imem_wdata;
    logic           s_core_rst;
    logic           s_core_en;
    logic           s_core_rw;
    logic [SAW:0]   s_word_count;
    logic [15:0]    s_cycle_count;
    logic           s_busy;
    logic           s_done;
    logic           s_err;

    imem_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RST_CYCLES(RC)) u_dut (
        .clk(clk), .rst(rst), .load_start(load_start), .run_len(run_len),
        .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
        .core_en(core_en), .core_rw(core_rw), .word_count(word_count),
        .cycle_count(cycle_count), .busy(busy), .done(done), .err(err)
    );

    imem_load_ctrl #(.ADDR_W(SAW), .DATA_W(DW), .RST_CYCLES(RC)) u_dut_small (
        .clk(clk), .rst(rst), .load_start(s_load_start), .run_len(s_run_len),
        .abort(s_abort), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_last(s_in_last), .in_ready(s_in_ready), .imem_we(s_imem_we),
        .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .core_rst(s_core_rst), .core_en(s_core_en), .core_rw(s_core_rw),
        .word_count(s_word_count), .cycle_count(s_cycle_count),
        .busy(s_busy), .done(s_done), .err(s_err)
    );

    int errors = 0;
    int checks = 0;

    // Program under test and observed activity
    logic [DW-1:0]  prog_q[$];
    logic [AW-1:0]  wa_q[$];
    logic [DW-1:0]  wd_q[$];
    logic [SAW-1:0] swa_q[$];
    logic [DW-1:0]  swd_q[$];
    int en_cnt   = 0;
    int hold_cnt = 0;
    int bad_we   = 0;
    int s_en_cnt = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            if (!in_valid) bad_we++;
        end
        if (core_en) en_cnt++;
        if (core_rst && core_rw) hold_cnt++;
        if (s_imem_we) begin
            swa_q.push_back(s_imem_addr);
            swd_q.push_back(s_imem_wdata);
        end
        if (s_core_en) s_en_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        en_cnt   = 0;
        hold_cnt = 0;
        bad_we   = 0;
    endtask

    task automatic make_prog(input int n);
        prog_q.delete();
        for (int i = 0; i < n; i++) prog_q.push_back($urandom);
    endtask

    task automatic pulse_start(input logic [15:0] rl);
        load_start = 1'b1;
        run_len    = rl;
        tick();
        load_start = 1'b0;
        run_len    = 16'($urandom);   // must already be latched
    endtask

    task automatic send_prog(input int gmin, input int gmax, input bit with_last);
        for (int i = 0; i < prog_q.size(); i++) begin
            int g;
            g = int'($urandom_range(gmax, gmin));
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = prog_q[i];
            in_last  = with_last && (i == prog_q.size() - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called on the first cycle after the final beat was accepted
    task automatic check_run(input string name, input int rl);
        int k;
        int bad;
        checks++;
        if (word_count !== (AW+1)'(prog_q.size())) begin
            errors++;
            $display("FAIL %s word_count: got %0d required %0d", name, word_count, prog_q.size());
        end
        k = 1;
        while (!done && k < RC + rl + 50) begin
            tick();
            k++;
        end
        checks++;
        if (done !== 1'b1 || k != RC + rl + 1) begin
            errors++;
            $display("FAIL %s done_latency: got done=%0b after %0d cycles required %0d", name, done, k, RC + rl + 1);
        end
        checks++;
        if (en_cnt != rl) begin
            errors++;
            $display("FAIL %s core_en_cycles: got %0d required %0d", name, en_cnt, rl);
        end
        checks++;
        if (hold_cnt != RC) begin
            errors++;
            $display("FAIL %s core_rst_hold: got %0d required %0d", name, hold_cnt, RC);
        end
        checks++;
        if ({err, core_en, core_rst, core_rw, busy} !== 5'b00010 || cycle_count !== 16'(rl)) begin
            errors++;
            $display("FAIL %s done_state: got err/en/rst/rw/busy=%b cycle_count=%0d required 00010 cycle_count=%0d",
                     name, {err, core_en, core_rst, core_rw, busy}, cycle_count, rl);
        end
        bad = 0;
        if (wa_q.size() != prog_q.size()) begin
            bad = 1;
        end else begin
            for (int i = 0; i < prog_q.size(); i++)
                if (wa_q[i] !== AW'(i) || wd_q[i] !== prog_q[i]) bad++;
        end
        checks++;
        if (bad != 0 || bad_we != 0) begin
            errors++;
            $display("FAIL %s writes: got %0d writes (%0d bad, %0d unqualified) required %0d in order from addr 0",
                     name, wa_q.size(), bad, bad_we, prog_q.size());
        end
    endtask

    // Load the program currently in prog_q and check the full sequence
    task automatic load_and_run(input string name, input int rl, input int gmin, input int gmax);
        clear_mon();
        pulse_start(16'(rl));
        checks++;
        if ({in_ready, busy, core_rst, core_rw, err} !== 5'b11100 || word_count !== '0) begin
            errors++;
            $display("FAIL %s load_entry: got ready/busy/rst/rw/err=%b word_count=%0d required 11100 word_count=0",
                     name, {in_ready, busy, core_rst, core_rw, err}, word_count);
        end
        send_prog(gmin, gmax, 1'b1);
        check_run(name, rl);
    endtask

    task automatic test_reset();
        logic [72:0] obs;
        logic [72:0] req;
        req = {1'b1, 4'b0, 8'h0, 32'h0, 9'h0, 16'h0, 3'b0};
        rst = 1'b1;
        tick();
        tick();
        obs = {core_rst, core_en, core_rw, in_ready, imem_we, imem_addr, imem_wdata,
               word_count, cycle_count, busy, done, err};
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", obs, req);
        end
        rst = 1'b0;
        tick();
        obs = {core_rst, core_en, core_rw, in_ready, imem_we, imem_addr, imem_wdata,
               word_count, cycle_count, busy, done, err};
        checks++;
        if (obs !== req || s_busy !== 1'b0 || s_core_rst !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: got %h required %h", obs, req);
        end
    endtask

    task automatic test_basic();
        prog_q.delete();
        prog_q.push_back(32'h00500093);
        prog_q.push_back(32'h00700113);
        prog_q.push_back(32'h00208133);
        load_and_run("basic", 3, 0, 0);
    endtask

    task automatic test_backpressure();
        prog_q.delete();
        prog_q.push_back(32'h00500093);
        prog_q.push_back(32'h00700113);
        prog_q.push_back(32'h00208133);
        load_and_run("backpressure", 3, 2, 2);
    endtask

    task automatic test_random_programs();
        for (int it = 0; it < 6; it++) begin
            make_prog(int'($urandom_range(12, 1)));
            load_and_run("random", int'($urandom_range(15, 1)), 0, 3);
        end
        // Final word lands exactly on the last address: not an overflow
        make_prog(1 << AW);
        load_and_run("full_memory", 1, 0, 0);
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_d[$];
        int bad;
        swa_q.delete();
        swd_q.delete();
        s_en_cnt     = 0;
        s_load_start = 1'b1;
        s_run_len    = 16'd7;
        tick();
        s_load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_in_valid = 1'b1;
            s_in_last  = 1'b0;
            s_in_data  = $urandom;
            exp_d.push_back(s_in_data);
            tick();
        end
        s_in_valid = 1'b0;
        checks++;
        if ({s_done, s_err, s_busy, s_in_ready} !== 4'b1100 || s_word_count !== 3'd4) begin
            errors++;
            $display("FAIL overflow_state: got done/err/busy/ready=%b word_count=%0d required 1100 word_count=4",
                     {s_done, s_err, s_busy, s_in_ready}, s_word_count);
        end
        bad = 0;
        if (swa_q.size() != 4) bad = 1;
        else for (int i = 0; i < 4; i++) if (swa_q[i] !== SAW'(i) || swd_q[i] !== exp_d[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL overflow_writes: got %0d writes (%0d bad) required 4 to addr 0..3", swa_q.size(), bad);
        end
        repeat (10) tick();
        checks++;
        if (s_en_cnt != 0 || s_done !== 1'b1 || s_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_no_run: got core_en cycles=%0d done=%0b err=%0b required 0 1 1", s_en_cnt, s_done, s_err);
        end
        s_load_start = 1'b1;
        tick();
        s_load_start = 1'b0;
        checks++;
        if (s_err !== 1'b0 || s_in_ready !== 1'b1 || s_word_count !== 3'd0) begin
            errors++;
            $display("FAIL overflow_reload: got err=%0b ready=%0b word_count=%0d required 0 1 0", s_err, s_in_ready, s_word_count);
        end
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
    endtask

    task automatic test_abort();
        int k;
        clear_mon();
        make_prog(1);
        pulse_start(16'd5);
        send_prog(0, 0, 1'b0);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = $urandom;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if ({busy, done, core_rst, core_en, core_rw, in_ready} !== 6'b001000) begin
            errors++;
            $display("FAIL abort_vs_last: got busy/done/rst/en/rw/ready=%b required 001000",
                     {busy, done, core_rst, core_en, core_rw, in_ready});
        end
        in_valid = 1'b1;
        #1;
        checks++;
        if (imem_we !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid_ignored: got imem_we=%0b in_ready=%0b required 0 0", imem_we, in_ready);
        end
        tick();
        in_valid = 1'b0;
        // Abort during RUN
        clear_mon();
        make_prog(2);
        pulse_start(16'd40);
        send_prog(0, 1, 1'b1);
        k = 0;
        while (!core_en && k < 20) begin tick(); k++; end
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({core_en, core_rst, core_rw, busy} !== 4'b0100 || en_cnt != 4) begin
            errors++;
            $display("FAIL abort_in_run: got en/rst/rw/busy=%b en_cycles=%0d required 0100 en_cycles=4",
                     {core_en, core_rst, core_rw, busy}, en_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int k;
        logic [72:0] obs;
        logic [72:0] req;
        req = {1'b1, 4'b0, 8'h0, 32'h0, 9'h0, 16'h0, 3'b0};
        clear_mon();
        make_prog(3);
        pulse_start(16'd20);
        send_prog(0, 2, 1'b1);
        k = 0;
        while (!(core_en && cycle_count == 16'd5) && k < 40) begin tick(); k++; end
        checks++;
        if (cycle_count !== 16'd5 || core_en !== 1'b1 || en_cnt != 5) begin
            errors++;
            $display("FAIL run_progress: got cycle_count=%0d en_cycles=%0d required 5 5", cycle_count, en_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {core_rst, core_en, core_rw, in_ready, imem_we, imem_addr, imem_wdata,
               word_count, cycle_count, busy, done, err};
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL reset_mid_run: got %h required %h", obs, req);
        end
    endtask

    task automatic test_unbounded_reload();
        int k;
        int bad;
        clear_mon();
        make_prog(2);
        pulse_start(16'd0);
        send_prog(0, 1, 1'b1);
        k = 0;
        while (!core_en && k < 20) begin tick(); k++; end
        checks++;
        if (core_en !== 1'b1 || cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL unbounded_start: got core_en=%0b cycle_count=%0d required 1 0", core_en, cycle_count);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (core_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || cycle_count !== 16'(en_cnt)) bad++;
            load_start = (i == 50);
            run_len    = 16'd3;
            tick();
        end
        load_start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL unbounded_run: got %0d bad cycles of 100 required 0", bad);
        end
        checks++;
        if (in_ready !== 1'b0 || core_en !== 1'b1 || cycle_count !== 16'd100) begin
            errors++;
            $display("FAIL start_ignored_in_run: got ready=%0b en=%0b cycle_count=%0d required 0 1 100",
                     in_ready, core_en, cycle_count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({core_en, core_rst, core_rw, busy, in_ready} !== 5'b01000 || cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL unbounded_abort: got en/rst/rw/busy/ready=%b cycle_count=%0d required 01000 0",
                     {core_en, core_rst, core_rw, busy, in_ready}, cycle_count);
        end
        make_prog(int'($urandom_range(6, 2)));
        load_and_run("reload", int'($urandom_range(9, 1)), 0, 2);
    endtask

    initial begin
        rst          = 1'b1;
        load_start   = 1'b0;
        run_len      = '0;
        abort        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        s_load_start = 1'b0;
        s_run_len    = '0;
        s_abort      = 1'b0;
        s_in_valid   = 1'b0;
        s_in_data    = '0;
        s_in_last    = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_random_programs();
        test_overflow();
        test_abort();
        test_reset_mid_run();
        test_unbounded_reload();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
